alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an iterative shift-add MUL and
// valid/ready handshakes on both the command and result sides.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   a, b, op_code     command operands and operation select
//   in_valid/in_ready command handshake (ready only in IDLE)
//   result, flag_*    registered result and Z/C/V/N flags
//   out_valid/ready   result handshake (valid only in DONE)
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept;
  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_mul;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  assign is_add = (op_code == OP_ADD);
  assign is_sub = (op_code == OP_SUB);
  assign is_and = (op_code == OP_AND);
  assign is_or  = (op_code == OP_OR);
  assign is_xor = (op_code == OP_XOR);
  assign is_mul = (op_code == OP_MUL);

  assign result = res_q;
  assign flag_z = flg_q[3];
  assign flag_c = flg_q[2];
  assign flag_v = flg_q[1];
  assign flag_n = flg_q[0];

  // Flag vector order: {Z, C, V, N}
  function automatic logic [3:0] mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             c,
    input logic             v
  );
    mk_flags = {(r == '0), c, v, r[MSB]};
  endfunction

  // Single-cycle datapath for every op except MUL.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    sum_w = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow (a < b).
    dif_w = {1'b0, a} - {1'b0, b};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (1'b1)
      is_add: begin
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (a[MSB] == b[MSB]) &&
                (alu_r[MSB] != a[MSB]);
      end
      is_sub: begin
        alu_r = dif_w[WIDTH-1:0];
        alu_c = dif_w[WIDTH];
        alu_v = (a[MSB] != b[MSB]) &&
                (alu_r[MSB] != a[MSB]);
      end
      is_and: alu_r = a & b;
      is_or:  alu_r = a | b;
      is_xor: alu_r = a ^ b;
      default: begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
    endcase
  end

  // Shift-add step: multiplicand moves left, multiplier
  // moves right, one multiplier bit consumed per cycle.
  logic [PW-1:0]    acc_step;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_ovf;
  logic             last_bit;

  assign acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_lo   = acc_step[WIDTH-1:0];
  assign mul_ovf  = |acc_step[PW-1:WIDTH];
  assign last_bit = (cnt_q == CNT_ONE);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flg_d   = flg_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mcand_d = {{WIDTH{1'b0}}, a};
            mplr_d  = b;
            acc_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = S_BUSY;
          end else begin
            res_d   = alu_r;
            flg_d   = mk_flags(alu_r, alu_c, alu_v);
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CNT_ONE;
        if (last_bit) begin
          res_d   = mul_lo;
          flg_d   = mk_flags(mul_lo, mul_ovf, mul_ovf);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      flg_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8).
// Expected {result, Z, C, V, N} pushed at drive, popped at output.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op_code = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;
  logic         flag_n;
  logic         out_valid;

  int checks = 0;
  int passes = 0;

  logic [W+3:0] sbq[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op_code   (op_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [W+3:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [2:0]   op
  );
    logic [W:0]    s;
    logic [PW-1:0] p;
    logic [W-1:0]  r;
    logic          c;
    logic          v;
    s = '0;
    p = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd1: begin
        r = x - y;
        c = (x < y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd5: r = x ^ y;
      3'd6: begin
        p = PW'(x) * PW'(y);
        r = p[W-1:0];
        c = |p[PW-1:W];
        v = c;
      end
      default: r = '0;
    endcase
    return {r, (r == '0), c, v, r[W-1]};
  endfunction

  function automatic logic [W+3:0] observed();
    return {result, flag_z, flag_c, flag_v, flag_n};
  endfunction

  // Drive a command and hold it until it is accepted.
  // Called at posedge+1; returns at posedge+1 after accept.
  task automatic issue(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [2:0]   op,
    input logic [W+3:0] exp
  );
    int n;
    a        = x;
    b        = y;
    op_code  = op;
    in_valid = 1'b1;
    sbq.push_back(exp);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid on negedges; lat counts cycles from accept.
  task automatic get_out(output int lat, output int lowrdy);
    lat    = -1;
    lowrdy = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (!in_ready) lowrdy++;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop_exp(output logic [W+3:0] e);
    if (sbq.size() > 0) e = sbq.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    int ov;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 12'h000}) begin
      $display("FAIL reset_init: got %h want %h",
               {out_valid, in_ready, observed()}, {2'b01, 12'h000});
    end else passes++;
    @(posedge clk);
    #1;
    issue(8'h10, 8'h20, 3'b110, model(8'h10, 8'h20, 3'b110));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 12'h000}) begin
      $display("FAIL reset_mid_mul: got %h want %h",
               {out_valid, in_ready, observed()}, {2'b01, 12'h000});
    end else passes++;
    ov = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    checks++;
    if (ov !== 0) begin
      $display("FAIL reset_stale: out_valid seen %0d times want 0", ov);
    end else passes++;
    sbq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_sub();
    logic [W-1:0] xs[4]  = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [W-1:0] ys[4]  = '{8'h01, 8'h01, 8'h07, 8'h01};
    logic [2:0]   ops[4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic [W+3:0] ex[4]  = '{{8'h00, 4'b1100}, {8'h80, 4'b0011},
                             {8'hFE, 4'b0101}, {8'h7F, 4'b0010}};
    logic [W+3:0] e;
    int lat;
    int lr;
    for (int i = 0; i < 4; i++) begin
      issue(xs[i], ys[i], ops[i], ex[i]);
      get_out(lat, lr);
      pop_exp(e);
      checks++;
      if (observed() !== e) begin
        $display("FAIL addsub%0d: got %h want %h", i, observed(), e);
      end else passes++;
      checks++;
      if (lat !== 1) begin
        $display("FAIL addsub%0d_lat: got %0d want 1", i, lat);
      end else passes++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] xs[2] = '{8'h10, 8'd12};
    logic [W-1:0] ys[2] = '{8'h20, 8'd11};
    logic [W+3:0] ex[2] = '{{8'h00, 4'b1110}, {8'h84, 4'b0001}};
    logic [W+3:0] e;
    int lat;
    int lr;
    for (int i = 0; i < 2; i++) begin
      issue(xs[i], ys[i], 3'b110, ex[i]);
      get_out(lat, lr);
      pop_exp(e);
      checks++;
      if (observed() !== e) begin
        $display("FAIL mul%0d: got %h want %h", i, observed(), e);
      end else passes++;
      checks++;
      if (lat !== W + 1) begin
        $display("FAIL mul%0d_lat: got %0d want %0d", i, lat, W + 1);
      end else passes++;
      checks++;
      if (lr !== W + 1) begin
        $display("FAIL mul%0d_busy: in_ready low %0d want %0d",
                 i, lr, W + 1);
      end else passes++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_logic();
    logic [W-1:0] xs[5]  = '{8'hF0, 8'hF0, 8'h5A, 8'hFF, 8'hAA};
    logic [W-1:0] ys[5]  = '{8'h3C, 8'h3C, 8'hA5, 8'hFF, 8'h0F};
    logic [2:0]   ops[5] = '{3'b010, 3'b011, 3'b100, 3'b111, 3'b101};
    logic [W+3:0] ex[5]  = '{{8'h30, 4'b0000}, {8'hFC, 4'b0001},
                             {8'h00, 4'b1000}, {8'h00, 4'b1000},
                             {8'hA5, 4'b0001}};
    logic [W+3:0] e;
    int lat;
    int lr;
    for (int i = 0; i < 5; i++) begin
      issue(xs[i], ys[i], ops[i], ex[i]);
      get_out(lat, lr);
      pop_exp(e);
      checks++;
      if (observed() !== e || lat !== 1) begin
        $display("FAIL logic%0d: got %h lat %0d want %h lat 1",
                 i, observed(), lat, e);
      end else passes++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [W+3:0] e;
    int lat;
    int lr;
    out_ready = 1'b0;
    issue(8'hAA, 8'h0F, 3'b101, {8'hA5, 4'b0001});
    get_out(lat, lr);
    pop_exp(e);
    a        = 8'h01;
    b        = 8'h02;
    op_code  = 3'b000;
    in_valid = 1'b1;
    sbq.push_back({8'h03, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        $display("FAIL bp_hold%0d: valid/ready %b want 10",
                 i, {out_valid, in_ready});
      end else passes++;
      checks++;
      if (observed() !== e) begin
        $display("FAIL bp_stable%0d: got %h want %h", i, observed(), e);
      end else passes++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL bp_release: valid/ready %b want 01",
               {out_valid, in_ready});
    end else passes++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    pop_exp(e);
    checks++;
    if (!out_valid || observed() !== e) begin
      $display("FAIL bp_next: valid %b got %h want %h",
               out_valid, observed(), e);
    end else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   op;
    logic [W+3:0] e;
    int lat;
    int lr;
    int want;
    for (int i = 0; i < 20; i++) begin
      x  = W'($urandom);
      y  = W'($urandom);
      op = 3'($urandom_range(0, 7));
      issue(x, y, op, model(x, y, op));
      get_out(lat, lr);
      pop_exp(e);
      want = (op == 3'b110) ? W + 1 : 1;
      checks++;
      if (observed() !== e || lat !== want) begin
        $display("FAIL b2b%0d op%0d %h,%h: got %h lat %0d want %h lat %0d",
                 i, op, x, y, observed(), lat, e, want);
      end else passes++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_logic();
    test_backpressure();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
